dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Posted-write store buffer between the processor's MEM stage and the data SRAM. Stores issued on the MEM bus are captured into a small FIFO and drained to the SRAM write port in cycles when the MEM stage is not loading. Loads read the SRAM combinationally and are corrected by forwarding from the youngest matching buffered store. The block asserts a stall request to the pipeline stall logic when it cannot accept a store, or when it cannot serve a load correctly.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- MEM_mem_addr  in  32  byte address from MEM stage; bits [31:2] used
- MEM_mem_cmd  in  2  `BUS_NONE` / `BUS_LOAD` / `BUS_STORE`
- MEM_mem_din  in  32  store data
- DM_mem_dout  out  32  load data returned to MEM stage (combinational)
- SB_stall  out  1  request to freeze IF..MEM; current MEM op not accepted
- SB_empty  out  1  no buffered stores
- SRAM_addr  out  32  SRAM address (word-aligned, bits [1:0] = 0)
- SRAM_we  out  1  SRAM write strobe for this cycle
- SRAM_din  out  32  SRAM write data
- SRAM_dout  in  32  SRAM asynchronous read data at SRAM_addr
- SRAM_ready  in  1  SRAM accepts a write this cycle

## Operation
- State: circular array of DEPTH entries {addr[31:2], data[31:0]}, head/tail pointers, count (0..DEPTH).
- Drain: drain = !empty && MEM_mem_cmd != `BUS_LOAD` && SRAM_ready. While drain is high: SRAM_we=1, SRAM_addr={head.addr,2'b00}, SRAM_din=head.data, and head advances at the edge.
- Load, cmd=`BUS_LOAD`: SRAM_addr={MEM_mem_addr[31:2],2'b00}, SRAM_we=0. DM_mem_dout = data of the youngest valid entry whose addr matches, otherwise SRAM_dout.
- Store, cmd=`BUS_STORE`: the store is accepted iff count<DEPTH, or drain is high in the same cycle. On acceptance, the entry is written at tail and tail advances.
- SB_stall = (cmd==`BUS_STORE`) && count==DEPTH && !drain.
- A stalled store is not written. The MEM stage holds the store, and it retries the next cycle.
- Store accepted with a simultaneous drain: count is unchanged, both pointers advance. This also applies when full.
- Idle cycles (`BUS_NONE`): SRAM_addr=head address when draining, otherwise 0.
- Pointers wrap modulo DEPTH. Full and empty are derived from count, not from pointer equality.
- Two stores to the same address both stay buffered and drain in order. Forwarding always selects the younger one.

## Timing
- Reset (rst=0 at the edge): count=0, head=tail=0, entries cleared. Outputs after reset: SB_empty=1, SB_stall=0, SRAM_we=0, SRAM_addr=0, SRAM_din=0, DM_mem_dout=SRAM_dout.
- If reset is asserted mid-operation, pending stores are discarded and are never written to SRAM.
- A store accepted at edge N is visible to forwarding from cycle N+1. Its earliest SRAM write is in cycle N+1.
- Load data path is zero-cycle (combinational) from MEM_mem_addr.
- SB_stall is combinational and may depend on SRAM_ready in the same cycle.
- Sustained stores with SRAM_ready=1 run at one store per cycle with no stall.

## Configuration
- `SB_FORWARD_EN` defined: load forwarding as described above.
- `SB_FORWARD_EN` undefined: no forwarding mux; DM_mem_dout=SRAM_dout.
  - A load whose word address matches any valid entry asserts SB_stall.
  - Draining is permitted during such a stalled load: the drain condition ignores `BUS_LOAD` when the load is stalled.
  - The stall clears once the matching entries have drained.

## Structure
- Shared package holds the entry struct (addr[29:0], data[31:0]) and the word-address extraction helper.
- `BUS_*` codes remain in the existing sys_defs header.
- One sub-module: `sb_match`, a combinational DEPTH-wide address compare with age-ordered youngest-hit select. It returns hit and index, and is used both for forwarding and for the no-forward stall.

## Test plan
- Reset, then store 0x100←0xAAAA_0001 with SRAM_ready=1 → cycle +1: SRAM_we=1, SRAM_addr=0x100, SRAM_din=0xAAAA_0001; then SB_empty=1.
- SRAM_ready=0, five back-to-back stores (DEPTH=4) → the fifth raises SB_stall. Raise SRAM_ready → the fifth is accepted the same cycle, and drains occur in issue order.
- Store 0x200←0x11, store 0x200←0x22, SRAM_ready=0, load 0x200 → DM_mem_dout=0x22, while SRAM_dout reads stale 0x0.
- Buffer full, store with SRAM_ready=1 → no stall, count stays 4, head and tail both advance; check pointer wrap after 8 more stores.
- Buffer holds 3 entries, rst=0 for one cycle → no SRAM_we afterwards, SB_empty=1.
- `SB_FORWARD_EN` undefined: pending store 0x300, load 0x300 → SB_stall=1 until the entry drains, then DM_mem_dout=SRAM_dout with the new value.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer.
// Holds the buffered-entry layout and the byte-to-word address helper.
package dmem_store_buffer_pkg;

    localparam int WORD_AW = 30;

    typedef struct packed {
        logic [WORD_AW-1:0] addr;
        logic [31:0]        data;
    } sb_entry_t;

    function automatic logic [WORD_AW-1:0] word_addr(input logic [31:0] byte_addr);
        return WORD_AW'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/dmem_store_buffer_match.sv
// Combinational compare of a word address against all live buffer entries.
// Scans oldest to youngest so the last hit (youngest store) wins.
module sb_match
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [WORD_AW-1:0] addr_i [DEPTH],
    input  logic [PTR_W-1:0]   head_i,
    input  logic [CNT_W-1:0]   count_i,
    input  logic [WORD_AW-1:0] key_i,
    output logic               hit_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && (addr_i[idx] == key_i)) begin
                hit_o = 1'b1;
                idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the MEM stage and the data SRAM.
// Optional macro SB_FORWARD_EN enables load forwarding; without it, loads hitting a buffered store stall.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_mem_addr,
    input  logic [1:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic        SB_stall,
    output logic        SB_empty,
    output logic [31:0] SRAM_addr,
    output logic        SRAM_we,
    output logic [31:0] SRAM_din,
    input  logic [31:0] SRAM_dout,
    input  logic        SRAM_ready
);

// Bus command encodings normally come from sys_defs; fall back if it was not included.
`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t          entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               is_load, is_store;
    logic               full, empty;
    logic               drain, store_acc, load_stall, drain_gate;
    logic [WORD_AW-1:0] mem_waddr;
    logic [WORD_AW-1:0] ent_addr [DEPTH];
    logic               hit;
    logic [PTR_W-1:0]   hit_idx;

    assign is_load   = (MEM_mem_cmd == `BUS_LOAD);
    assign is_store  = (MEM_mem_cmd == `BUS_STORE);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_waddr = word_addr(MEM_mem_addr);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = entries_q[i].addr;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_match (
        .addr_i  (ent_addr),
        .head_i  (head_q),
        .count_i (count_q),
        .key_i   (mem_waddr),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

`ifdef SB_FORWARD_EN
    assign load_stall  = 1'b0;
    assign drain_gate  = !is_load;
    assign DM_mem_dout = (is_load && hit) ? entries_q[hit_idx].data : SRAM_dout;
`else
    // A load that hits a pending store waits, and lets the buffer drain underneath it.
    logic unused_hit_idx;
    assign unused_hit_idx = ^hit_idx;
    assign load_stall  = is_load && hit;
    assign drain_gate  = !is_load || load_stall;
    assign DM_mem_dout = SRAM_dout;
`endif

    assign drain     = !empty && drain_gate && SRAM_ready;
    assign store_acc = is_store && (!full || drain);
    assign SB_stall  = (is_store && full && !drain) || load_stall;
    assign SB_empty  = empty;

    always_comb begin
        SRAM_we   = 1'b0;
        SRAM_addr = '0;
        SRAM_din  = '0;
        if (drain) begin
            SRAM_we   = 1'b1;
            SRAM_addr = {entries_q[head_q].addr, 2'b00};
            SRAM_din  = entries_q[head_q].data;
        end else if (is_load) begin
            SRAM_addr = {mem_waddr, 2'b00};
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (store_acc) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (store_acc && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (drain && !store_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (store_acc) begin
                entries_q[tail_q] <= '{addr: mem_waddr, data: MEM_mem_din};
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed testbench for dmem_store_buffer with an SRAM model and write scoreboard.
// Forwarding checks follow SB_FORWARD_EN; otherwise the load-stall behaviour is exercised.
module tb_dmem_store_buffer;

`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_mem_addr;
  logic [1:0]  MEM_mem_cmd;
  logic [31:0] MEM_mem_din;
  logic [31:0] DM_mem_dout;
  logic        SB_stall;
  logic        SB_empty;
  logic [31:0] SRAM_addr;
  logic        SRAM_we;
  logic [31:0] SRAM_din;
  logic [31:0] SRAM_dout;
  logic        SRAM_ready;

  logic [31:0] sram [0:1023];
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_drn   = 0;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_mem_addr (MEM_mem_addr),
    .MEM_mem_cmd  (MEM_mem_cmd),
    .MEM_mem_din  (MEM_mem_din),
    .DM_mem_dout  (DM_mem_dout),
    .SB_stall     (SB_stall),
    .SB_empty     (SB_empty),
    .SRAM_addr    (SRAM_addr),
    .SRAM_we      (SRAM_we),
    .SRAM_din     (SRAM_din),
    .SRAM_dout    (SRAM_dout),
    .SRAM_ready   (SRAM_ready)
  );

  // clock / SRAM model
  always #5 clk = ~clk;
  assign SRAM_dout = sram[SRAM_addr[11:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every SRAM write must match the oldest outstanding store
  always @(negedge clk) begin
    if (SRAM_we && SRAM_ready) begin
      mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("sram_write", {SRAM_addr, SRAM_din}, mon_e);
      sram[SRAM_addr[11:2]] = SRAM_din;
      n_drn++;
    end
  end

  // driver tasks
  task automatic drive(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] din, input logic rdy);
    MEM_mem_cmd  = cmd;
    MEM_mem_addr = addr;
    MEM_mem_din  = din;
    SRAM_ready   = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    rst = 1'b0;
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b0);
    tick;
    tick;

    // reset state
    check("rst_empty", 64'(SB_empty), 64'd1);
    check("rst_stall", 64'(SB_stall), 64'd0);
    check("rst_we",    64'(SRAM_we), 64'd0);
    check("rst_addr",  64'(SRAM_addr), 64'd0);
    check("rst_din",   64'(SRAM_din), 64'd0);
    check("rst_dout",  64'(DM_mem_dout), 64'd0);
    rst = 1'b1;

    // single store drains the next cycle
    drive(`BUS_STORE, 32'h100, 32'hAAAA_0001, 1'b1);
    check("t1_stall", 64'(SB_stall), 64'd0);
    expect_write(32'h100, 32'hAAAA_0001);
    tick;
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
    check("t1_we",   64'(SRAM_we), 64'd1);
    check("t1_addr", 64'(SRAM_addr), 64'h100);
    check("t1_din",  64'(SRAM_din), 64'hAAAA_0001);
    tick;
    check("t1_empty", 64'(SB_empty), 64'd1);
    check("t1_we_off", 64'(SRAM_we), 64'd0);

    // fill, stall on fifth, release with SRAM_ready
    for (int i = 0; i < 4; i++) begin
      drive(`BUS_STORE, 32'h10 + 32'(4 * i), 32'(i + 1), 1'b0);
      check("t2_fill_stall", 64'(SB_stall), 64'd0);
      expect_write(32'h10 + 32'(4 * i), 32'(i + 1));
      tick;
    end
    drive(`BUS_STORE, 32'h20, 32'h5, 1'b0);
    check("t2_full_stall", 64'(SB_stall), 64'd1);
    check("t2_count_full", 64'(dut.count_q), 64'd4);
    tick;
    check("t2_held_stall", 64'(SB_stall), 64'd1);
    check("t2_held_count", 64'(dut.count_q), 64'd4);
    drive(`BUS_STORE, 32'h20, 32'h5, 1'b1);
    check("t2_rel_stall", 64'(SB_stall), 64'd0);
    check("t2_rel_addr", 64'(SRAM_addr), 64'h10);
    expect_write(32'h20, 32'h5);
    tick;
    check("t2_count_swap", 64'(dut.count_q), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
      check("t2_drain_addr", 64'(SRAM_addr), 64'(32'h10 + 32'(4 * i)));
      tick;
    end
    check("t2_empty", 64'(SB_empty), 64'd1);

    // full buffer with concurrent drain: no stall, pointers wrap
    for (int i = 0; i < 4; i++) begin
      drive(`BUS_STORE, 32'h400 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
      expect_write(32'h400 + 32'(4 * i), 32'hB0 + 32'(i));
      tick;
    end
    check("t3_count", 64'(dut.count_q), 64'd4);
    for (int i = 0; i < 8; i++) begin
      drive(`BUS_STORE, 32'h410 + 32'(4 * i), 32'hC0 + 32'(i), 1'b1);
      check("t3_stall", 64'(SB_stall), 64'd0);
      expect_write(32'h410 + 32'(4 * i), 32'hC0 + 32'(i));
      tick;
      check("t3_count_hold", 64'(dut.count_q), 64'd4);
    end
    // 18 stores accepted and 14 drained since reset: both pointers at 2
    check("t3_head", 64'(dut.head_q), 64'd2);
    check("t3_tail", 64'(dut.tail_q), 64'd2);
    for (int i = 0; i < 4; i++) begin
      drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
      tick;
    end
    check("t3_empty", 64'(SB_empty), 64'd1);

`ifdef SB_FORWARD_EN
    // youngest-store forwarding while SRAM is stale
    drive(`BUS_STORE, 32'h200, 32'h11, 1'b0);
    expect_write(32'h200, 32'h11);
    tick;
    drive(`BUS_STORE, 32'h200, 32'h22, 1'b0);
    expect_write(32'h200, 32'h22);
    tick;
    drive(`BUS_LOAD, 32'h200, 32'h0, 1'b0);
    check("t4_fwd_dout", 64'(DM_mem_dout), 64'h22);
    check("t4_fwd_stall", 64'(SB_stall), 64'd0);
    check("t4_fwd_we", 64'(SRAM_we), 64'd0);
    check("t4_fwd_addr", 64'(SRAM_addr), 64'h200);
    drive(`BUS_LOAD, 32'h204, 32'h0, 1'b0);
    check("t4_miss_dout", 64'(DM_mem_dout), 64'h0);
    drive(`BUS_LOAD, 32'h200, 32'h0, 1'b1);
    check("t4_load_blocks_drain", 64'(SRAM_we), 64'd0);
    check("t4_fwd_dout2", 64'(DM_mem_dout), 64'h22);
    tick;
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
    tick;
    tick;
    drive(`BUS_LOAD, 32'h200, 32'h0, 1'b1);
    check("t4_sram_dout", 64'(DM_mem_dout), 64'h22);
    check("t4_empty", 64'(SB_empty), 64'd1);
`else
    // load hitting a pending store stalls until it drains
    drive(`BUS_STORE, 32'h300, 32'h33, 1'b0);
    expect_write(32'h300, 32'h33);
    tick;
    drive(`BUS_LOAD, 32'h300, 32'h0, 1'b0);
    check("t4_hit_stall", 64'(SB_stall), 64'd1);
    check("t4_hit_we", 64'(SRAM_we), 64'd0);
    tick;
    drive(`BUS_LOAD, 32'h300, 32'h0, 1'b1);
    check("t4_drain_stall", 64'(SB_stall), 64'd1);
    check("t4_drain_we", 64'(SRAM_we), 64'd1);
    check("t4_drain_addr", 64'(SRAM_addr), 64'h300);
    tick;
    check("t4_clear_stall", 64'(SB_stall), 64'd0);
    check("t4_load_dout", 64'(DM_mem_dout), 64'h33);
    check("t4_empty", 64'(SB_empty), 64'd1);
    drive(`BUS_STORE, 32'h304, 32'h44, 1'b0);
    expect_write(32'h304, 32'h44);
    tick;
    drive(`BUS_LOAD, 32'h308, 32'h0, 1'b1);
    check("t4_miss_stall", 64'(SB_stall), 64'd0);
    check("t4_miss_we", 64'(SRAM_we), 64'd0);
    tick;
    check("t4_miss_count", 64'(dut.count_q), 64'd1);
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
    tick;
    drive(`BUS_STORE, 32'h200, 32'h11, 1'b0);
    expect_write(32'h200, 32'h11);
    tick;
    drive(`BUS_STORE, 32'h200, 32'h22, 1'b0);
    expect_write(32'h200, 32'h22);
    tick;
    drive(`BUS_LOAD, 32'h200, 32'h0, 1'b1);
    check("t4_dup_stall1", 64'(SB_stall), 64'd1);
    check("t4_dup_din1", 64'(SRAM_din), 64'h11);
    tick;
    check("t4_dup_stall2", 64'(SB_stall), 64'd1);
    check("t4_dup_din2", 64'(SRAM_din), 64'h22);
    tick;
    check("t4_dup_stall3", 64'(SB_stall), 64'd0);
    check("t4_dup_dout", 64'(DM_mem_dout), 64'h22);
`endif

    // reset discards pending stores
    for (int i = 0; i < 3; i++) begin
      drive(`BUS_STORE, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0);
      tick;
    end
    check("t5_count", 64'(dut.count_q), 64'd3);
    rst = 1'b0;
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b0);
    tick;
    rst = 1'b1;
    check("t5_empty", 64'(SB_empty), 64'd1);
    check("t5_count0", 64'(dut.count_q), 64'd0);
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_we", 64'(SRAM_we), 64'd0);
      tick;
    end
    drive(`BUS_STORE, 32'h600, 32'h66, 1'b1);
    expect_write(32'h600, 32'h66);
    tick;
    drive(`BUS_NONE, 32'h0, 32'h0, 1'b1);
    check("t5_post_addr", 64'(SRAM_addr), 64'h600);
    tick;
    check("t5_post_empty", 64'(SB_empty), 64'd1);

    check("sb_outstanding", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
